// File: rtl/uart_boot_pkg.sv
// Shared types for the UART boot loader: loader states and byte-lane counter.
package uart_boot_pkg;

  typedef enum logic [1:0] {S_LEN, S_DATA, S_RUN, S_ERR} state_e;

  localparam int BYTES_PER_WORD = 4;

  typedef logic [$clog2(BYTES_PER_WORD)-1:0] bcnt_t;

  localparam bcnt_t BCNT_LAST = bcnt_t'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/uart_boot_loader_fifo.sv
// Run-phase byte FIFO: extra-MSB pointers, registered head/valid, pop-frees-slot on full.
module byte_fifo #(
  parameter int FIFO_LOG2 = 3,
  parameter int W         = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         valid_o,
  output logic         drop_o
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  typedef logic [FIFO_LOG2:0] ptr_t;

  ptr_t         wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] head_q, head_d;
  logic         valid_q, valid_d;
  logic         empty, full, pop_ok, push_ok;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[FIFO_LOG2] != rd_q[FIFO_LOG2]) &&
                   (wr_q[FIFO_LOG2-1:0] == rd_q[FIFO_LOG2-1:0]);
  assign pop_ok  = pop_i & ~empty;
  assign push_ok = push_i & (~full | pop_ok);
  assign drop_o  = push_i & ~push_ok;

  // Head is looked up at the post-update read pointer so it is ready the cycle after.
  always_comb begin
    wr_d    = push_ok ? wr_q + ptr_t'(1) : wr_q;
    rd_d    = pop_ok  ? rd_q + ptr_t'(1) : rd_q;
    valid_d = (wr_d != rd_d);
    if (push_ok && (wr_q[FIFO_LOG2-1:0] == rd_d[FIFO_LOG2-1:0]))
      head_d = din_i;
    else
      head_d = mem_q[rd_d[FIFO_LOG2-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_q    <= '0;
      rd_q    <= '0;
      head_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      head_q  <= head_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[FIFO_LOG2-1:0]] <= din_i;
  end

  assign dout_o  = head_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/uart_boot_loader.sv
// Boot loader behind the UART receiver: loads a length-prefixed big-endian program
// into instruction memory, then forwards received bytes to the core through a FIFO.
//
//   state  | meaning
//   S_LEN  | assembling the 32-bit word count, MSB first
//   S_DATA | assembling program words and writing them to imem
//   S_RUN  | boot complete; bytes go to the run-phase FIFO
//   S_ERR  | load aborted; terminal until reset
module uart_boot_loader
  import uart_boot_pkg::*;
#(
  parameter int IMEM_ADDR_W = 15,
  parameter int FIFO_LOG2   = 3
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   rx_ferr,
  output logic                   imem_we,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  output logic [31:0]            imem_wdata,
  output logic                   boot_done,
  output logic                   load_err,
  output logic [7:0]             in_data,
  output logic                   in_valid,
  input  logic                   in_ready,
  output logic                   rx_overflow
);

  localparam logic [32:0] MAX_LEN = 33'(1) << IMEM_ADDR_W;

  state_e                 state_q, state_d;
  bcnt_t                  bcnt_q, bcnt_d;
  logic [31:0]            len_q, len_d, word_q, word_d;
  logic [IMEM_ADDR_W-1:0] widx_q, widx_d, addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic                   we_q, we_d, done_q, done_d, err_q, err_d, ovf_q, ovf_d;
  logic                   acc, ferr, last_byte, last_word, len_zero, len_big;
  logic [31:0]            len_shift, word_shift;
  logic                   fifo_push, fifo_drop;

  assign acc        = rx_valid & ~rx_ferr;
  assign ferr       = rx_valid & rx_ferr;
  assign last_byte  = (bcnt_q == BCNT_LAST);
  assign len_shift  = {len_q[23:0], rx_data};
  assign word_shift = {word_q[23:0], rx_data};
  assign len_zero   = (len_shift == 32'd0);
  assign len_big    = ({1'b0, len_shift} > MAX_LEN);
  assign last_word  = (32'(widx_q) == len_q - 32'd1);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_LEN;
      bcnt_q  <= '0;
      len_q   <= '0;
      word_q  <= '0;
      widx_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      len_q   <= len_d;
      word_q  <= word_d;
      widx_q  <= widx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LEN: begin
        if (ferr) state_d = S_ERR;
        else if (acc && last_byte) begin
          if (len_zero)     state_d = S_RUN;
          else if (len_big) state_d = S_ERR;
          else              state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (ferr) state_d = S_ERR;
        else if (acc && last_byte && last_word) state_d = S_RUN;
      end
      default: state_d = state_q;
    endcase
  end

  // boot_done follows S_RUN by one cycle so it lands after the final imem strobe;
  // the zero-length case sets it directly to meet the same one-cycle latency.
  always_comb begin
    bcnt_d    = bcnt_q;
    len_d     = len_q;
    word_d    = word_q;
    widx_d    = widx_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    done_d    = done_q | (state_q == S_RUN);
    err_d     = err_q;
    ovf_d     = ovf_q;
    fifo_push = 1'b0;
    case (state_q)
      S_LEN: begin
        if (ferr) err_d = 1'b1;
        else if (acc) begin
          len_d  = len_shift;
          bcnt_d = bcnt_q + bcnt_t'(1);
          if (last_byte) begin
            widx_d = '0;
            if (len_zero)     done_d = 1'b1;
            else if (len_big) err_d  = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (ferr) err_d = 1'b1;
        else if (acc) begin
          word_d = word_shift;
          bcnt_d = bcnt_q + bcnt_t'(1);
          if (last_byte) begin
            we_d    = 1'b1;
            addr_d  = widx_q;
            wdata_d = word_shift;
            widx_d  = widx_q + IMEM_ADDR_W'(1);
          end
        end
      end
      S_RUN: begin
        fifo_push = acc;
        ovf_d     = ovf_q | ferr | fifo_drop;
      end
      default: ;
    endcase
  end

  byte_fifo #(.FIFO_LOG2(FIFO_LOG2), .W(8)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (fifo_push),
    .din_i   (rx_data),
    .pop_i   (in_valid & in_ready),
    .dout_o  (in_data),
    .valid_o (in_valid),
    .drop_o  (fifo_drop)
  );

  assign imem_we     = we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign boot_done   = done_q;
  assign load_err    = err_q;
  assign rx_overflow = ovf_q;

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Controller sitting directly behind the UART receiver, consuming its byte stream.
- After reset it runs a program-load protocol:
  - Receives a 32-bit word count, then that many 32-bit big-endian words.
  - Writes each word into instruction memory at consecutive addresses, then releases the core via boot_done.
- After boot, redirects every received byte into a small FIFO drained by the core's input instruction.

Parameters:
- IMEM_ADDR_W, 15, instruction-memory word-address width; maximum program length is 2**IMEM_ADDR_W words.
- FIFO_LOG2, 3, log2 of the run-phase byte FIFO depth (default 8 entries).

Ports:
- clk  in  1  system clock
- rstn  in  1  reset; synchronous, active-low
- rx_data  in  8  received byte, valid only when rx_valid=1
- rx_valid  in  1  single-cycle pulse, one per received byte
- rx_ferr  in  1  framing error for the byte pulsed in the same cycle
- imem_we  out  1  instruction-memory write strobe, single-cycle
- imem_addr  out  IMEM_ADDR_W  word address for imem_we
- imem_wdata  out  32  word for imem_we
- boot_done  out  1  level; core may start fetching
- load_err  out  1  sticky; load aborted
- in_data  out  8  FIFO head byte
- in_valid  out  1  FIFO non-empty
- in_ready  in  1  core pops head when in_valid & in_ready
- rx_overflow  out  1  sticky; run-phase byte dropped (FIFO full or framing error)

Behaviour:
- Reset: all outputs 0; state S_LEN; byte counter 0, word counter 0, FIFO empty. Reset mid-load abandons the load with no further imem_we; memory contents left as written.
- Accept rule: a byte is consumed only in a cycle with rx_valid=1. rx_data is ignored otherwise.
- S_LEN:
  - Shift bytes into a 32-bit length register, MSB first.
  - On the 4th byte, go to S_DATA with word address 0.
  - If length == 0: boot_done=1 the next cycle, state S_RUN.
  - If length > 2**IMEM_ADDR_W: load_err=1 the next cycle, state S_ERR.
- S_DATA:
  - Shift bytes into a 32-bit word register, MSB first.
  - On the 4th byte of a word: the next cycle drives imem_we=1 for exactly one cycle, with imem_addr = word index and imem_wdata = the assembled word.
  - Word index increments after each write.
  - When the written index equals length-1, boot_done rises in the cycle after that imem_we pulse, and state becomes S_RUN.
  - The byte counter wraps 3→0; no byte is lost between consecutive words.
- Framing error in S_LEN or S_DATA (rx_ferr=1 with rx_valid=1):
  - The byte is discarded and no imem_we is issued for a partial word.
  - load_err=1 the next cycle; state S_ERR.
- S_ERR: terminal until reset. Bytes ignored; boot_done stays 0; in_valid stays 0.
- S_RUN (boot_done held 1 until reset):
  - Each accepted byte is pushed into the FIFO. in_valid rises the cycle after the push when the FIFO was empty.
  - Pop when in_valid & in_ready; in_data advances the cycle after the pop.
  - Push while full: byte dropped, rx_overflow=1 the next cycle, FIFO unchanged.
  - Push and pop in the same cycle while full: both succeed, no overflow.
  - Push and pop in the same cycle while empty: push only (no bypass).
  - rx_ferr with rx_valid: byte not pushed; rx_overflow=1.
- FIFO pointers are FIFO_LOG2+1 bits wide. Full/empty is determined by MSB compare; pointers wrap modulo 2**(FIFO_LOG2+1).
- All outputs are registered. No combinational path from rx_* or in_ready to any output.

Decomposition:
- Package uart_boot_pkg holds:
  - state enum {S_LEN, S_DATA, S_RUN, S_ERR};
  - BYTES_PER_WORD=4;
  - the byte-counter type.
- Sub-module byte_fifo, parameterised on FIFO_LOG2 and width 8:
  - synchronous push/pop, full/empty flags;
  - registered head output;
  - simultaneous push+pop handled as stated above.
- The loader FSM, length/word shifters and imem write logic live in uart_boot_loader.

Test Plan:
- Program load: send bytes 00 00 00 02, DE AD BE EF, 01 23 45 67 → imem_we at addr 0 with 0xDEADBEEF, imem_we at addr 1 with 0x01234567, boot_done one cycle after the second strobe.
- Zero length: send 00 00 00 00 → no imem_we; boot_done=1 one cycle after the 4th byte. Then send 0x41 → in_valid=1 with in_data=0x41.
- Framing error mid-word: length 1, then bytes AA BB, then CC with rx_ferr → no imem_we; load_err=1; subsequent bytes produce no response. Reset → all outputs 0, fresh load works.
- Oversize length: 2**IMEM_ADDR_W+1 → load_err=1, boot_done never rises.
- FIFO overflow: in S_RUN with in_ready=0, send 9 bytes 0x00–0x08 → first 8 retained, rx_overflow=1 after the 9th. Drain with in_ready=1 → reads 0x00..0x07 in order.
- Full-FIFO simultaneous push/pop: with FIFO full and in_ready=1, push 0x55 → accepted, rx_overflow stays 0, 0x55 read last.
